iboot_stream_loader: RTL and testbench

Parametrised boot loader that copies a boot image from the serial-flash byte reader into main memory before the core is released. It issues byte read requests to the flash reader, pops returned bytes, and packs them into memory words of configurable width and byte order. Each word is written through the memory-interface request port using the lock handshake. An optional trailing checksum word is verified, with done/error status reported to the boot sequencer.

---
 rtl/iboot_stream_loader_if.sv | 32 +++
 rtl/iboot_stream_loader.sv | 131 +++++++++++++
 tb/tb_iboot_stream_loader.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/iboot_stream_loader_if.sv
// Flash-reader and memory-interface signal bundle for the boot-image loader.
// The loader connects through `master`; the flash reader / memory side uses `slave`.
interface iboot_stream_loader_if #(
  parameter int P_FLASH_ADDR_W = 23,
  parameter int P_MEM_ADDR_W   = 25,
  parameter int P_WORD_BYTES   = 4
);
  logic                        oFLASH_RQ_REQ;
  logic                        iFLASH_RQ_BUSY;
  logic [P_FLASH_ADDR_W-1:0]   oFLASH_RQ_ADDR;
  logic                        oFLASH_RD_REQ;
  logic                        iFLASH_RD_EMPTY;
  logic [7:0]                  iFLASH_RD_DATA;
  logic                        oMEMIF_REQ_VALID;
  logic                        oMEMIF_REQ_RW;
  logic [P_WORD_BYTES-1:0]     oMEMIF_REQ_DQM;
  logic [P_MEM_ADDR_W-1:0]     oMEMIF_REQ_ADDR;
  logic [8*P_WORD_BYTES-1:0]   oMEMIF_REQ_DATA;
  logic                        iMEMIF_REQ_LOCK;

  modport master (
    output oFLASH_RQ_REQ, oFLASH_RQ_ADDR, oFLASH_RD_REQ,
    output oMEMIF_REQ_VALID, oMEMIF_REQ_RW, oMEMIF_REQ_DQM, oMEMIF_REQ_ADDR, oMEMIF_REQ_DATA,
    input  iFLASH_RQ_BUSY, iFLASH_RD_EMPTY, iFLASH_RD_DATA, iMEMIF_REQ_LOCK
  );

  modport slave (
    input  oFLASH_RQ_REQ, oFLASH_RQ_ADDR, oFLASH_RD_REQ,
    input  oMEMIF_REQ_VALID, oMEMIF_REQ_RW, oMEMIF_REQ_DQM, oMEMIF_REQ_ADDR, oMEMIF_REQ_DATA,
    output iFLASH_RQ_BUSY, iFLASH_RD_EMPTY, iFLASH_RD_DATA, iMEMIF_REQ_LOCK
  );
endinterface

// File: rtl/iboot_stream_loader.sv
// Boot loader: streams image bytes from the serial-flash reader, packs them into memory
// words and writes them out, optionally verifying a trailing checksum word.
module iboot_stream_loader #(
  parameter int P_FLASH_ADDR_W = 23,
  parameter int P_MEM_ADDR_W   = 25,
  parameter int P_WORD_BYTES   = 4,
  parameter int P_WORD_COUNT   = 32768,
  parameter int P_FLASH_BASE   = 0,
  parameter int P_MEM_BASE     = 0,
  parameter int P_CHECKSUM     = 1
) (
  input  logic                  iCLOCK,
  input  logic                  iRESET,
  input  logic                  iSTART,
  input  logic                  iBIG_ENDIAN,
  iboot_stream_loader_if.master bus,
  output logic                  oIBOOT_VALID,
  output logic                  oIBOOT_DONE,
  output logic                  oIBOOT_ERR,
  output logic [31:0]           oIBOOT_WORDS
);
  localparam int DW   = 8 * P_WORD_BYTES;
  localparam int NB   = (P_WORD_COUNT + P_CHECKSUM) * P_WORD_BYTES;
  localparam int RQ_W = $clog2(NB + 1);
  localparam int BI_W = (P_WORD_BYTES > 1) ? $clog2(P_WORD_BYTES) : 1;

  localparam logic [BI_W-1:0] LAST_LANE  = BI_W'(P_WORD_BYTES - 1);
  localparam logic [RQ_W-1:0] RQ_TOTAL   = RQ_W'(NB);
  localparam logic [31:0]     WORD_TOTAL = 32'(P_WORD_COUNT);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_GET   = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERROR = 3'd5;

  logic [2:0]      state;
  logic [RQ_W-1:0] rq_cnt;
  logic [BI_W-1:0] byte_idx;
  logic [BI_W-1:0] lane;
  logic [31:0]     word_cnt;
  logic [DW-1:0]   word;
  logic [DW-1:0]   sum;
  logic            big_endian;
  logic            trailer;
  logic            run;
  logic            rq_fire;
  logic            take_byte;
  logic            accept;

  assign run       = !(state == S_IDLE || state == S_DONE || state == S_ERROR);
  assign rq_fire   = run && (rq_cnt < RQ_TOTAL) && !bus.iFLASH_RQ_BUSY;
  assign take_byte = (state == S_GET) && !bus.iFLASH_RD_EMPTY;
  assign accept    = (state == S_WRITE) && !bus.iMEMIF_REQ_LOCK;
  // Big-endian puts the first byte of a word into the most significant lane.
  assign lane      = big_endian ? (LAST_LANE - byte_idx) : byte_idx;

  assign bus.oFLASH_RQ_REQ    = rq_fire;
  assign bus.oFLASH_RQ_ADDR   = P_FLASH_ADDR_W'(P_FLASH_BASE) + P_FLASH_ADDR_W'(rq_cnt);
  assign bus.oFLASH_RD_REQ    = take_byte;
  assign bus.oMEMIF_REQ_VALID = accept;
  assign bus.oMEMIF_REQ_RW    = 1'b1;
  assign bus.oMEMIF_REQ_DQM   = '0;
  assign bus.oMEMIF_REQ_ADDR  = P_MEM_ADDR_W'(P_MEM_BASE) + P_MEM_ADDR_W'(word_cnt);
  assign bus.oMEMIF_REQ_DATA  = word;

  assign oIBOOT_VALID = run;
  assign oIBOOT_DONE  = (state == S_DONE);
  assign oIBOOT_ERR   = (state == S_ERROR);
  assign oIBOOT_WORDS = word_cnt;

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      state      <= S_IDLE;
      rq_cnt     <= '0;
      byte_idx   <= '0;
      word_cnt   <= '0;
      word       <= '0;
      sum        <= '0;
      big_endian <= 1'b0;
      trailer    <= 1'b0;
    end else begin
      // The request side runs ahead of packing, bounded only by the byte total.
      if (rq_fire) rq_cnt <= rq_cnt + 1'b1;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (iSTART) begin
            rq_cnt     <= '0;
            byte_idx   <= '0;
            word_cnt   <= '0;
            sum        <= '0;
            trailer    <= 1'b0;
            big_endian <= iBIG_ENDIAN;
            state      <= S_GET;
          end
        end
        S_GET: begin
          if (take_byte) begin
            word[{lane, 3'b000} +: 8] <= bus.iFLASH_RD_DATA;
            if (byte_idx == LAST_LANE) begin
              byte_idx <= '0;
              state    <= trailer ? S_CHECK : S_WRITE;
            end else begin
              byte_idx <= byte_idx + 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (accept) begin
            word_cnt <= word_cnt + 32'd1;
            sum      <= sum + word;
            if (word_cnt + 32'd1 == WORD_TOTAL) begin
              if (P_CHECKSUM != 0) begin
                trailer <= 1'b1;
                state   <= S_GET;
              end else begin
                state   <= S_DONE;
              end
            end else begin
              state <= S_GET;
            end
          end
        end
        // The trailer word sits in the packing register and is compared, never written.
        S_CHECK: state <= (word == sum) ? S_DONE : S_ERROR;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_iboot_stream_loader.sv
// Bench for iboot_stream_loader: three configurations, each with a flash/memory model.
`timescale 1ns/1ps
module tb_iboot_stream_loader;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g
    localparam int WB = (gi == 2) ? 2 : 4;
    localparam int WC = (gi == 2) ? 6 : 4;
    localparam int CK = (gi == 0) ? 0 : 1;
    localparam int FB = (gi == 2) ? 16 : 0;
    localparam int MB = (gi == 2) ? 8 : 0;
    localparam int NB = (WC + CK) * WB;
    localparam int DW = 8 * WB;
    localparam logic [63:0] MASK = (64'd1 << DW) - 64'd1;

    logic rst = 1'b0, start = 1'b0, be = 1'b0, be_run = 1'b0, rnd = 1'b0;
    logic busy = 1'b0, estall = 1'b0, lock = 1'b0, ended = 1'b0;
    int lock_word = -1, lock_cyc = 0;
    int n_wr = 0, n_rq = 0, fh = 0, ft = 0;
    logic [7:0]  img [0:63];
    logic [7:0]  fq  [0:63];
    logic [63:0] mem [0:15];
    logic valid, done, err;
    logic [31:0] words;

    iboot_stream_loader_if #(.P_FLASH_ADDR_W(8), .P_MEM_ADDR_W(6), .P_WORD_BYTES(WB)) bus ();

    iboot_stream_loader #(
      .P_FLASH_ADDR_W(8), .P_MEM_ADDR_W(6), .P_WORD_BYTES(WB), .P_WORD_COUNT(WC),
      .P_FLASH_BASE(FB), .P_MEM_BASE(MB), .P_CHECKSUM(CK)
    ) dut (
      .iCLOCK(clk), .iRESET(rst), .iSTART(start), .iBIG_ENDIAN(be), .bus(bus),
      .oIBOOT_VALID(valid), .oIBOOT_DONE(done), .oIBOOT_ERR(err), .oIBOOT_WORDS(words)
    );

    assign bus.iFLASH_RQ_BUSY  = busy;
    assign bus.iFLASH_RD_EMPTY = (fh == ft) || estall;
    assign bus.iFLASH_RD_DATA  = fq[fh % 64];
    assign bus.iMEMIF_REQ_LOCK = lock;

    // Word w of the image: byte j carries significance j (LE) or WB-1-j (BE).
    function automatic logic [63:0] exp_word(input int w);
      logic [63:0] r;
      r = '0;
      for (int j = 0; j < WB; j++)
        r = r | (64'(img[w*WB + j]) << (8 * (be_run ? (WB - 1 - j) : j)));
      return r;
    endfunction

    // Flash reader returns requested bytes in order; memory captures accepted writes.
    always @(posedge clk or posedge rst) begin
      if (rst) begin
        fh <= 0; ft <= 0; n_wr <= 0; n_rq <= 0; ended <= 1'b0;
      end else begin
        if (bus.oFLASH_RD_REQ && fh != ft) fh <= fh + 1;
        if (bus.oFLASH_RQ_REQ) begin
          fq[ft % 64] <= img[n_rq % 64];
          ft <= ft + 1;
          n_rq <= n_rq + 1;
        end
        if (bus.oMEMIF_REQ_VALID) begin
          mem[n_wr % 16] <= 64'(bus.oMEMIF_REQ_DATA);
          n_wr <= n_wr + 1;
        end
        if (start && !valid) begin
          n_wr <= 0; n_rq <= 0; ended <= 1'b0;
        end
      end
    end

    always @(posedge clk) begin
      #2;
      busy   = rnd && ($urandom_range(0, 2) == 0);
      estall = rnd && ($urandom_range(0, 2) == 0);
      if (lock_word >= 0 && n_wr == lock_word && lock_cyc < 9) begin
        lock = 1'b1;
        lock_cyc++;
      end else begin
        lock = rnd && ($urandom_range(0, 3) == 0);
      end
    end

    always @(negedge clk) begin
      if (!rst) begin
        chk("rw_const", bus.oMEMIF_REQ_RW, 1);
        chk("dqm_const", bus.oMEMIF_REQ_DQM, 0);
        if (bus.oFLASH_RQ_REQ) begin
          chk("rq_addr", bus.oFLASH_RQ_ADDR, FB + n_rq);
          chk("rq_bound", n_rq < NB, 1);
          chk("rq_busy", busy, 0);
        end
        if (bus.oMEMIF_REQ_VALID) begin
          chk("wr_addr", bus.oMEMIF_REQ_ADDR, MB + n_wr);
          chk("wr_data", bus.oMEMIF_REQ_DATA, exp_word(n_wr) & MASK);
          chk("wr_bound", n_wr < WC, 1);
          chk("wr_owned", valid, 1);
        end
        if ((done || err) && !ended) begin : endcheck
          logic [63:0] s;
          logic pass;
          s = '0;
          for (int w = 0; w < WC; w++) s = (s + exp_word(w)) & MASK;
          pass = (CK == 0) || ((exp_word(WC) & MASK) == s);
          ended <= 1'b1;
          chk("model_done", done, pass);
          chk("model_err", err, !pass);
          chk("model_words", words, WC);
          chk("model_nwr", n_wr, WC);
          chk("model_nrq", n_rq, NB);
        end
      end
    end
  end

`define RSTCHK(G, FBV, MBV) \
  chk("rst_rq_req", g[G].bus.oFLASH_RQ_REQ, 0); \
  chk("rst_rq_addr", g[G].bus.oFLASH_RQ_ADDR, FBV); \
  chk("rst_rd_req", g[G].bus.oFLASH_RD_REQ, 0); \
  chk("rst_wr_valid", g[G].bus.oMEMIF_REQ_VALID, 0); \
  chk("rst_wr_rw", g[G].bus.oMEMIF_REQ_RW, 1); \
  chk("rst_wr_addr", g[G].bus.oMEMIF_REQ_ADDR, MBV); \
  chk("rst_wr_data", g[G].bus.oMEMIF_REQ_DATA, 0); \
  chk("rst_status", {g[G].valid, g[G].done, g[G].err}, 0); \
  chk("rst_words", g[G].words, 0);

`define RUN(G, BEV) \
  g[G].be = BEV; g[G].be_run = BEV; \
  @(negedge clk); g[G].start = 1'b1; \
  @(negedge clk); g[G].start = 1'b0;

`define WAIT_END(G) \
  begin \
    int t; \
    t = 0; \
    while (!(g[G].done || g[G].err) && t < 2000) begin @(negedge clk); t++; end \
    chk("run_timeout", t < 2000, 1); \
    @(negedge clk); \
  end

  initial begin
    for (int i = 0; i < 64; i++) begin
      g[0].img[i] = 8'(i);
      g[1].img[i] = 8'h00;
      g[2].img[i] = 8'h00;
    end
    for (int i = 0; i < 16; i++) begin
      g[0].mem[i] = '0; g[1].mem[i] = '0; g[2].mem[i] = '0;
    end
    g[1].img[0] = 8'd1; g[1].img[4] = 8'd2; g[1].img[8] = 8'd3; g[1].img[12] = 8'd4;
    g[1].img[16] = 8'h0A;
    for (int i = 0; i < 12; i++) g[2].img[i] = 8'(8'h10 + i);
    g[2].img[12] = 8'h7E; g[2].img[13] = 8'h84;

    g[0].rst = 1'b1; g[1].rst = 1'b1; g[2].rst = 1'b1;
    @(posedge clk); #1;
    `RSTCHK(0, 0, 0)
    `RSTCHK(1, 0, 0)
    `RSTCHK(2, 16, 8)
    @(negedge clk);
    g[0].rst = 1'b0; g[1].rst = 1'b0; g[2].rst = 1'b0;
    @(negedge clk);

    // Little-endian, no checksum.
    `RUN(0, 1'b0)
    `WAIT_END(0)
    chk("le_done", g[0].done, 1);
    chk("le_err", g[0].err, 0);
    chk("le_words", g[0].words, 4);
    chk("le_nrq", g[0].n_rq, 16);
    chk("le_w0", g[0].mem[0], 64'h03020100);
    chk("le_w1", g[0].mem[1], 64'h07060504);
    chk("le_w2", g[0].mem[2], 64'h0B0A0908);
    chk("le_w3", g[0].mem[3], 64'h0F0E0D0C);

    // Big-endian with lock on word 2; a mid-run start and endian flip must be ignored.
    g[0].lock_word = 2; g[0].lock_cyc = 0;
    `RUN(0, 1'b1)
    repeat (3) @(negedge clk);
    g[0].be = 1'b0; g[0].start = 1'b1;
    @(negedge clk); g[0].start = 1'b0;
    `WAIT_END(0)
    chk("be_done", g[0].done, 1);
    chk("be_nwr", g[0].n_wr, 4);
    chk("be_lock_seen", g[0].lock_cyc, 9);
    chk("be_w0", g[0].mem[0], 64'h00010203);
    chk("be_w2", g[0].mem[2], 64'h08090A0B);
    g[0].lock_word = -1;

    // Reset mid-run after two words, then a full rerun from the memory base.
    `RUN(0, 1'b0)
    begin
      int t;
      t = 0;
      while (g[0].n_wr < 2 && t < 500) begin @(negedge clk); t++; end
      chk("mid_wait", t < 500, 1);
    end
    #2; g[0].rst = 1'b1; #1;
    `RSTCHK(0, 0, 0)
    @(negedge clk); g[0].rst = 1'b0;
    for (int i = 0; i < 16; i++) g[0].mem[i] = '0;
    `RUN(0, 1'b0)
    `WAIT_END(0)
    chk("rerun_done", g[0].done, 1);
    chk("rerun_words", g[0].words, 4);
    chk("rerun_w0", g[0].mem[0], 64'h03020100);
    chk("rerun_w3", g[0].mem[3], 64'h0F0E0D0C);

    // Checksum pass, fail, then corrected restart.
    `RUN(1, 1'b0)
    `WAIT_END(1)
    chk("ck_done", g[1].done, 1);
    chk("ck_err", g[1].err, 0);
    chk("ck_nwr", g[1].n_wr, 4);
    chk("ck_nrq", g[1].n_rq, 20);
    chk("ck_w3", g[1].mem[3], 64'h4);
    g[1].img[16] = 8'h0B;
    `RUN(1, 1'b0)
    `WAIT_END(1)
    chk("ckf_err", g[1].err, 1);
    chk("ckf_done", g[1].done, 0);
    chk("ckf_nwr", g[1].n_wr, 4);
    g[1].img[16] = 8'h0A;
    `RUN(1, 1'b0)
    `WAIT_END(1)
    chk("ckr_done", g[1].done, 1);
    chk("ckr_words", g[1].words, 4);

    // Two-byte words with random busy, empty and lock stalls.
    g[2].rnd = 1'b1;
    `RUN(2, 1'b0)
    `WAIT_END(2)
    g[2].rnd = 1'b0;
    chk("st_done", g[2].done, 1);
    chk("st_err", g[2].err, 0);
    chk("st_nrq", g[2].n_rq, 14);
    chk("st_nwr", g[2].n_wr, 6);
    chk("st_w0", g[2].mem[0], 64'h1110);
    chk("st_w5", g[2].mem[5], 64'h1B1A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end
endmodule
